// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: character codes and segment constants shared by the scrolling display.
package seg_disp_pkg;

    // Codes 0x00-0x0F are the hex digits 0-F; these named codes follow them.
    typedef enum logic [4:0] {
        CH_BLANK = 5'h10,
        CH_DASH  = 5'h11,
        CH_L     = 5'h12,
        CH_H     = 5'h13,
        CH_P     = 5'h14,
        CH_U     = 5'h15,
        CH_R     = 5'h16,
        CH_N     = 5'h17
    } char_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg_glyph_rom.sv
// seg_glyph_rom: char code to active-low {g,f,e,d,c,b,a} glyph; unknown codes render blank.
module seg_glyph_rom
    import seg_disp_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        case (code)
            5'h00:   glyph = 7'b1000000;
            5'h01:   glyph = 7'b1111001;
            5'h02:   glyph = 7'b0100100;
            5'h03:   glyph = 7'b0110000;
            5'h04:   glyph = 7'b0011001;
            5'h05:   glyph = 7'b0010010;
            5'h06:   glyph = 7'b0000010;
            5'h07:   glyph = 7'b1111000;
            5'h08:   glyph = 7'b0000000;
            5'h09:   glyph = 7'b0010000;
            5'h0A:   glyph = 7'b0001000;
            5'h0B:   glyph = 7'b0000011;
            5'h0C:   glyph = 7'b1000110;
            5'h0D:   glyph = 7'b0100001;
            5'h0E:   glyph = 7'b0000110;
            5'h0F:   glyph = 7'b0001110;
            CH_DASH: glyph = 7'b0111111;
            CH_L:    glyph = 7'b1000111;
            CH_H:    glyph = 7'b0001001;
            CH_P:    glyph = 7'b0001100;
            CH_U:    glyph = 7'b1000001;
            CH_R:    glyph = 7'b0101111;
            CH_N:    glyph = 7'b0101011;
            default: glyph = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/scroll_text_display.sv
// scroll_text_display: scrolls a writable char buffer across a multiplexed common-anode 7-segment bank.
module scroll_text_display
    import seg_disp_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int MAX_LEN     = 16,
    parameter int REFRESH_DIV = 65536
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         step_tick,
    input  logic                         scroll_en,
    input  logic                         dir,
    input  logic [$clog2(MAX_LEN+1)-1:0] msg_len,
    input  logic                         wr_en,
    input  logic [$clog2(MAX_LEN+1)-1:0] wr_addr,
    input  logic [4:0]                   wr_data,
    output logic [N_DIGITS-1:0]          an,
    output logic [6:0]                   seg,
    output logic                         wrap
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int PW = $clog2(MAX_LEN + N_DIGITS + 1);
    localparam int DW = $clog2(REFRESH_DIV);
    localparam int SW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;

    logic [4:0]          msg_q [MAX_LEN];
    logic [4:0]          msg_d [MAX_LEN];
    logic [PW-1:0]       pos_q, pos_d;
    logic [DW-1:0]       div_q, div_d;
    logic [SW-1:0]       scan_q, scan_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                wrap_q, wrap_d;
    logic                tc;
    logic [4:0]          char_cur;
    logic [6:0]          glyph;
    int                  span, p, nxt, rel;

    // Address width leaves room for out-of-range indices, which match no entry and are dropped.
    always_comb begin
        msg_d = msg_q;
        for (int i = 0; i < MAX_LEN; i++)
            if (wr_en && wr_addr == LW'(i)) msg_d[i] = wr_data;
    end

    // A shrunken message can leave pos beyond the span; the next step restarts it at 0.
    always_comb begin
        span   = int'(msg_len) + N_DIGITS;
        p      = int'(pos_q);
        nxt    = p;
        wrap_d = 1'b0;
        if (msg_len == '0) begin
            nxt = 0;
        end else if (step_tick && scroll_en) begin
            if (p >= span || (!dir && p == span - 1)) begin
                nxt    = 0;
                wrap_d = 1'b1;
            end else if (dir && p == 0) begin
                nxt    = span - 1;
                wrap_d = 1'b1;
            end else begin
                nxt = dir ? p - 1 : p + 1;
            end
        end
        pos_d = PW'(nxt);
    end

    always_comb begin
        tc     = div_q == DW'(REFRESH_DIV - 1);
        div_d  = tc ? '0 : div_q + DW'(1);
        scan_d = !tc ? scan_q : (scan_q == SW'(N_DIGITS - 1) ? '0 : scan_q + SW'(1));
    end

    // Digit d at position p shows msg[p-d] when that index lies inside the active message.
    always_comb begin
        rel      = int'(pos_q) - int'(scan_q);
        char_cur = CH_BLANK;
        for (int i = 0; i < MAX_LEN; i++)
            if (rel == i && rel < int'(msg_len)) char_cur = msg_q[i];
    end

    seg_glyph_rom u_rom (
        .code  (char_cur),
        .glyph (glyph)
    );

    always_comb begin
        seg_d = glyph;
        an_d  = glyph == SEG_BLANK ? '1 : ~(N_DIGITS'(1) << scan_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q  <= '0;
            div_q  <= '0;
            scan_q <= '0;
            an_q   <= '1;
            seg_q  <= SEG_BLANK;
            wrap_q <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) msg_q[i] <= CH_BLANK;
        end else begin
            pos_q  <= pos_d;
            div_q  <= div_d;
            scan_q <= scan_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            wrap_q <= wrap_d;
            msg_q  <= msg_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_scroll_text_display.sv
// tb_scroll_text_display: directed scroll scenarios checked against a position/buffer model of the display.
module tb_scroll_text_display;

    localparam logic [6:0] G_B = 7'h7F, G_C = 7'h46, G_0 = 7'h40, G_A = 7'h08;
    localparam logic [6:0] G_L = 7'h47, G_H = 7'h09, G_8 = 7'h00;

    logic       clk = 1'b0;
    logic       reset, step_tick, scroll_en, dir, wr_en;
    logic [4:0] msg_len, wr_addr, wr_data;
    logic [3:0] an4;
    logic [2:0] an3;
    logic [6:0] seg4, seg3;
    logic       wrap4, wrap3;

    int n_vec = 0;
    int n_err = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    scroll_text_display #(.N_DIGITS(4), .MAX_LEN(16), .REFRESH_DIV(4)) dut (
        .clk(clk), .reset(reset), .step_tick(step_tick), .scroll_en(scroll_en), .dir(dir),
        .msg_len(msg_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .an(an4), .seg(seg4), .wrap(wrap4)
    );

    scroll_text_display #(.N_DIGITS(3), .MAX_LEN(16), .REFRESH_DIV(4)) dut3 (
        .clk(clk), .reset(reset), .step_tick(step_tick), .scroll_en(scroll_en), .dir(dir),
        .msg_len(msg_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .an(an3), .seg(seg3), .wrap(wrap3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: message buffer, per-bank position and scan slot, and the registered outputs they imply.
    logic [6:0] gl [24] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
                            7'h7F, 7'h3F, 7'h47, 7'h09, 7'h0C, 7'h41, 7'h2F, 7'h2B};
    logic [4:0] m_buf [16];
    int         m_pos [2];
    int         m_scan [2];
    int         m_div;
    logic [3:0] e_an [2];
    logic [6:0] e_seg [2];
    logic       e_wrap [2];

    function automatic int ndig(input int k);
        return k == 0 ? 4 : 3;
    endfunction

    function automatic int nxt_pos(input int p, input int n, input int len, input logic go, input logic d);
        int s = len + n;
        if (len == 0) return 0;
        if (!go) return p;
        if (p >= s) return 0;
        return d ? (p + s - 1) % s : (p + 1) % s;
    endfunction

    function automatic logic wrapped(input int p, input int n, input int len, input logic go, input logic d);
        int s = len + n;
        return len != 0 && go && (p >= s || (d ? p == 0 : p == s - 1));
    endfunction

    function automatic logic [6:0] shown(input int p, input int dg, input int len);
        int r = p - dg;
        logic [4:0] c = (r >= 0 && r < len) ? m_buf[r] : 5'h10;
        return c < 5'd24 ? gl[c] : 7'h7F;
    endfunction

    function automatic logic [3:0] an_of(input logic [6:0] g, input int dg, input int n);
        logic [3:0] mask = n == 4 ? 4'hF : 4'h7;
        return g == 7'h7F ? mask : mask & ~(4'b1 << dg);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_pos[k]  <= 0;
                m_scan[k] <= 0;
                e_an[k]   <= 4'hF;
                e_seg[k]  <= 7'h7F;
                e_wrap[k] <= 1'b0;
            end
            m_div <= 0;
            for (int i = 0; i < 16; i++) m_buf[i] <= 5'h10;
        end else begin
            for (int k = 0; k < 2; k++) begin
                e_seg[k]  <= shown(m_pos[k], m_scan[k], int'(msg_len));
                e_an[k]   <= an_of(shown(m_pos[k], m_scan[k], int'(msg_len)), m_scan[k], ndig(k));
                e_wrap[k] <= wrapped(m_pos[k], ndig(k), int'(msg_len), step_tick && scroll_en, dir);
                m_pos[k]  <= nxt_pos(m_pos[k], ndig(k), int'(msg_len), step_tick && scroll_en, dir);
                m_scan[k] <= m_div == 3 ? (m_scan[k] + 1) % ndig(k) : m_scan[k];
            end
            m_div <= (m_div + 1) % 4;
            if (wr_en && wr_addr < 5'd16) m_buf[wr_addr[3:0]] <= wr_data;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("an4", an4, e_an[0]);
            chk("seg4", seg4, e_seg[0]);
            chk("wrap4", wrap4, e_wrap[0]);
            chk("an3", an3, e_an[1][2:0]);
            chk("seg3", seg3, e_seg[1]);
            chk("wrap3", wrap3, e_wrap[1]);
        end
    end

    task automatic tick(input logic exp_wrap, input string nm);
        step_tick = 1'b1;
        @(negedge clk);
        step_tick = 1'b0;
        chk(nm, wrap4, exp_wrap);
    endtask

    task automatic wr(input int a, input logic [4:0] c);
        wr_en   = 1'b1;
        wr_addr = 5'(a);
        wr_data = c;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Gathers one full scan of the 4-digit bank into a {d3,d2,d1,d0} glyph frame.
    task automatic check_frame(input string nm, input logic [27:0] exp);
        logic [6:0] fr [4];
        for (int d = 0; d < 4; d++) fr[d] = 7'h7F;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            for (int d = 0; d < 4; d++) if (an4 == ~(4'b1 << d)) fr[d] = seg4;
            @(negedge clk);
        end
        chk(nm, {4'h0, fr[3], fr[2], fr[1], fr[0]}, {4'h0, exp});
    endtask

    task automatic wait_an3(input logic [2:0] e, input string nm);
        int n = 0;
        while (an3 !== e && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(nm, an3, e);
    endtask

    task automatic next_an3(input logic [2:0] e, input string nm);
        logic [2:0] cur;
        int n = 0;
        cur = an3;
        while (an3 === cur && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(nm, an3, e);
    endtask

    logic [4:0] cola [9] = '{5'h0C, 5'h00, 5'h0C, 5'h0A, 5'h11, 5'h0C, 5'h00, 5'h12, 5'h0A};

    initial begin
        reset = 1'b1; step_tick = 1'b0; scroll_en = 1'b0; dir = 1'b0;
        msg_len = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        chk("reset_an", an4, 4'hF);
        chk("reset_seg", seg4, 7'h7F);
        chk("reset_wrap", wrap4, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) wr(i, cola[i]);
        msg_len = 5'd9;
        scroll_en = 1'b1;
        check_frame("frame_p0", {G_B, G_B, G_B, G_C});
        for (int k = 1; k <= 13; k++) begin
            tick(k == 13, "wrap_fwd");
            if (k == 1) check_frame("frame_p1", {G_B, G_B, G_C, G_0});
            if (k == 3) check_frame("frame_p3", {G_C, G_0, G_C, G_A});
            if (k == 12) check_frame("frame_p12", {G_B, G_B, G_B, G_B});
        end
        chk("pos_after_wrap", m_pos[0], 0);
        check_frame("frame_rewrap", {G_B, G_B, G_B, G_C});

        dir = 1'b1;
        tick(1'b1, "wrap_rev");
        chk("pos_rev", m_pos[0], 12);
        check_frame("frame_rev12", {G_B, G_B, G_B, G_B});
        tick(1'b0, "wrap_rev11");
        check_frame("frame_rev11", {G_A, G_B, G_B, G_B});

        scroll_en = 1'b0;
        for (int k = 0; k < 5; k++) tick(1'b0, "wrap_frozen");
        chk("pos_frozen", m_pos[0], 11);
        check_frame("frame_frozen", {G_A, G_B, G_B, G_B});
        scroll_en = 1'b1;
        tick(1'b0, "wrap_rev10");
        check_frame("frame_rev10", {G_L, G_A, G_B, G_B});
        msg_len = 5'd2;
        tick(1'b1, "wrap_shrink");
        chk("pos_shrink", m_pos[0], 0);

        msg_len = 5'd9;
        dir = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 5'h13;
        tick(1'b0, "wrap_wr_tick");
        wr_en = 1'b0;
        check_frame("frame_wr_tick", {G_B, G_B, G_H, G_0});
        wr(16, 5'h11);
        check_frame("frame_oob_wr", {G_B, G_B, G_H, G_0});

        for (int k = 0; k < 6; k++) tick(1'b0, "wrap_to7");
        chk("pos_p7", m_pos[0], 7);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_an", an4, 4'hF);
        chk("midreset_seg", seg4, 7'h7F);
        chk("midreset_wrap", wrap4, 1'b0);
        reset = 1'b0;
        check_frame("frame_cleared0", {G_B, G_B, G_B, G_B});
        for (int k = 0; k < 3; k++) tick(1'b0, "wrap_cleared");
        check_frame("frame_cleared3", {G_B, G_B, G_B, G_B});

        for (int i = 0; i < 9; i++) wr(i, 5'h08);
        tick(1'b0, "wrap_p4");
        tick(1'b0, "wrap_p5");
        check_frame("frame_8888", {G_8, G_8, G_8, G_8});
        wait_an3(3'b110, "scan3_slot0");
        next_an3(3'b101, "scan3_slot1");
        next_an3(3'b011, "scan3_slot2");
        next_an3(3'b110, "scan3_wrap0");

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
